// File: rtl/out_writeback_pkg.sv
// Shared types and constants for the output write-back stage.
// Build option: OUT_WRITEBACK_DROP_CNT_EN adds a saturating dropped-beat counter port.
package out_writeback_pkg;

  localparam int unsigned PIX_W       = 16;
  localparam int unsigned POX_DEFAULT = 3;
  localparam int unsigned BEAT_W      = POX_DEFAULT * PIX_W;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } owb_state_e;

endpackage

// File: rtl/out_writeback_if.sv
// Write-request channel from the write-back stage to the output SRAM arbiter.
// Address/data are qualified by wr_valid and consumed on wr_valid & wr_ready.
interface out_writeback_if
  import out_writeback_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = BEAT_W
);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/owb_fifo.sv
// Show-ahead synchronous FIFO; the head entry is always visible on rdata.
// A push is taken when full provided a pop happens in the same cycle.
module owb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PTR_W + 1)'(DEPTH));
  assign level   = cnt_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Idle output reads as zero so the write bus is quiet outside transfers.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/out_writeback.sv
// Output write-back stage: buffers post-processing beats, attaches row-strided addresses and
// issues them to the output SRAM. OUT_WRITEBACK_DROP_CNT_EN adds the drop_cnt output.
module out_writeback
  import out_writeback_pkg::*;
#(
  parameter int unsigned POX    = 3,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [CNT_W-1:0]       row_beats,
  input  logic [ADDR_W-1:0]      row_stride,
  input  logic [CNT_W-1:0]       tile_beats,
  input  logic [POX*PIX_W-1:0]   post_out,
  input  logic                   post_out_valid,
  out_writeback_if.master        wr,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
`ifdef OUT_WRITEBACK_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0]       drop_cnt
`endif
);

  localparam int unsigned BW    = POX * PIX_W;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  owb_state_e state_q, state_d;

  logic [CNT_W-1:0]  row_beats_q, tile_beats_q, col_q, beat_cnt_q;
  logic [ADDR_W-1:0] row_stride_q, row_base_q, beat_addr;
  logic              overflow_q;

  logic              in_run, start_fire, pop, beat_run, accept, drop, last_beat, drain_done;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic [ADDR_W+BW-1:0] fifo_rdata;

  assign start_fire = start & (state_q == StIdle);
  assign pop        = wr.wr_valid & wr.wr_ready;
  assign beat_run   = post_out_valid & in_run;
  assign accept     = beat_run & (~fifo_full | pop);
  // Anything not taken into the FIFO is a loss, including stray beats outside RUN.
  assign drop       = post_out_valid & ~accept;
  assign last_beat  = beat_run & ((beat_cnt_q + CNT_W'(1)) == tile_beats_q);
  // Look ahead on the final pop so done follows it by exactly one cycle.
  assign drain_done = fifo_empty | (pop & (fifo_level == LVL_W'(1)));
  assign beat_addr  = row_base_q + ADDR_W'(col_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start)      state_d = StRun;
      StRun:   if (last_beat)  state_d = StDrain;
      StDrain: if (drain_done) state_d = StDone;
      StDone:                  state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
  end

  always_comb begin
    in_run = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (state_q)
      StRun: begin
        in_run = 1'b1;
        busy   = 1'b1;
      end
      StDrain: busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Address and beat counters advance on every RUN beat, dropped or not, so a lossy tile
  // still terminates and later beats keep their correct addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_beats_q  <= '0;
      tile_beats_q <= '0;
      row_stride_q <= '0;
      row_base_q   <= '0;
      col_q        <= '0;
      beat_cnt_q   <= '0;
    end else if (start_fire) begin
      row_beats_q  <= row_beats;
      tile_beats_q <= tile_beats;
      row_stride_q <= row_stride;
      row_base_q   <= base_addr;
      col_q        <= '0;
      beat_cnt_q   <= '0;
    end else if (beat_run) begin
      beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      if (col_q == row_beats_q - CNT_W'(1)) begin
        col_q      <= '0;
        row_base_q <= row_base_q + row_stride_q;
      end else begin
        col_q <= col_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= (overflow_q & ~start_fire) | drop;
    end
  end

  assign overflow = overflow_q;

`ifdef OUT_WRITEBACK_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = start_fire ? '0 : drop_cnt_q;
    if (drop && (drop_cnt_d != '1)) begin
      drop_cnt_d = drop_cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  owb_fifo #(
    .WIDTH (ADDR_W + BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata ({beat_addr, post_out}),
    .pop   (wr.wr_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign wr.wr_valid = ~fifo_empty;
  assign wr.wr_addr  = fifo_rdata[ADDR_W+BW-1:BW];
  assign wr.wr_data  = fifo_rdata[BW-1:0];

endmodule

// File: doc/out_writeback.md
# out_writeback

Output write-back stage that sits directly downstream of the post-processing top level. It consumes the CONV+ReLU+BN result stream (POX pixels per beat, valid-only, no back-pressure) and buffers it in a small FIFO. It generates row-strided output-memory addresses and presents address/data words to the output SRAM arbiter over a valid/ready handshake, counting beats so it can signal tile completion.

## Interface
- POX, 3, pixels per beat (each 16-bit fixed point).
- DEPTH, 8, FIFO depth in beats; power of two, ≥2.
- ADDR_W, 16, output memory address width (word = one beat).
- CNT_W, 16, width of beat/row counters.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle tile start pulse; honoured only in IDLE.
- base_addr  in  ADDR_W  first word address of the tile; latched on start.
- row_beats  in  CNT_W  beats per output row (≥1); latched on start.
- row_stride  in  ADDR_W  address distance between row starts (≥ row_beats); latched on start.
- tile_beats  in  CNT_W  total beats in the tile (≥1); latched on start.
- post_out  in  POX*16  result beat from post-processing.
- post_out_valid  in  1  beat valid; cannot be stalled.
- wr_valid  out  1  write request valid.
- wr_ready  in  1  memory side accepts the write.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  POX*16  write data.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the last beat has been written.
- overflow  out  1  sticky: a beat arrived while the FIFO was full, or arrived outside RUN; cleared by start or rst.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on start, latch the config, clear counters and overflow, and go to RUN.
- RUN: each post_out_valid beat is pushed with its address.
  - If the accept count reaches tile_beats on a push, go to DRAIN.
- DRAIN: no pushes. When the FIFO is empty and no write is outstanding, go to DONE.
- DONE: assert done for one cycle, then go to IDLE.
- Address generation (per accepted beat):
  - addr = row_base + col.
  - col increments each beat. At col == row_beats-1, col returns to 0 and row_base += row_stride.
  - row_base starts at base_addr.
  - Addition wraps modulo 2^ADDR_W.
- Push acceptance:
  - Accepted if the FIFO is not full, or if a pop occurs in the same cycle (full with wr_ready & wr_valid).
  - Otherwise the beat is dropped, overflow is set, and the address/accept counters still advance, so the tile completes and later addresses stay correct.
- Beats in IDLE, DRAIN or DONE are dropped and set overflow; counters are unaffected.
- Pop occurs on wr_valid & wr_ready.
- Data passes through unmodified; no arithmetic on the payload.
- start while not in IDLE is ignored.
- rst mid-tile: FIFO emptied, state IDLE, in-flight beats discarded, no done.

## Timing
- Reset values: wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0. FIFO empty, state IDLE.
- The FIFO is show-ahead with registered outputs. A beat accepted in cycle t can appear on wr_valid/wr_addr/wr_data at t+1 at the earliest.
- wr_addr/wr_data hold stable while wr_valid=1 and wr_ready=0.
- wr_valid never depends combinationally on wr_ready.
- Full throughput of one beat per cycle is sustained when wr_ready is held high.
- done fires one cycle after the cycle in which the final pop completes (DRAIN→DONE transition is registered).
- overflow is set in the cycle after the offending beat.

## Configuration
- OUT_WRITEBACK_DROP_CNT_EN:
  - Defined: adds output drop_cnt [CNT_W-1:0] counting every dropped beat. It saturates at all-ones and clears on start or rst.
  - Undefined: the port and counter are absent; overflow alone reports loss.

## Structure
- Shared package: state enum (IDLE/RUN/DRAIN/DONE) and the beat width constant (POX*16).
- Sub-module owb_fifo, parameterised (WIDTH, DEPTH):
  - Show-ahead synchronous FIFO carrying {addr, data}.
  - Provides full/empty.
  - Supports push-when-full-with-pop.

## Test plan
- Basic tile: base_addr=0x100, row_beats=2, row_stride=4, tile_beats=6, wr_ready=1, 6 consecutive beats -> writes at 0x100,0x101,0x104,0x105,0x108,0x109 in order, data unchanged, done pulses once, overflow=0.
- Back-pressure: DEPTH=8, wr_ready=0 for 8 beats then a 9th beat -> 9th dropped, overflow=1, drop_cnt=1 (macro on). After wr_ready=1, 8 writes are issued with the 9th address skipped, then done.
- Simultaneous push/pop when full: FIFO full, wr_ready=1 and post_out_valid=1 in the same cycle -> beat accepted, no overflow, occupancy stays 8.
- Stray beats: post_out_valid in IDLE -> no write, overflow=1. A following start clears overflow to 0.
- Reset mid-tile: rst after 3 of 6 beats with wr_ready=0 -> wr_valid=0 the next cycle, busy=0, no done. A new start runs a clean tile from the new base_addr.
- Address wrap: ADDR_W=16, base_addr=0xFFFE, row_beats=1, row_stride=1, tile_beats=4 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
